// File: rtl/ser2par8_pkg.sv
// ser2par8_pkg: shared widths, FSM state encoding and parity helper for the
// ser2par8 serial-to-parallel byte assembler.
package ser2par8_pkg;

    localparam int unsigned DATA_W = 8;   // assembled byte width
    localparam int unsigned CNT_W  = 3;   // bit-position counter width
    localparam int unsigned FCNT_W = 8;   // delivered-frame counter width

    // PARITY is only reachable when SER2PAR8_PARITY_EN is defined.
    typedef enum logic [1:0] {
        SHIFT  = 2'd0,
        PARITY = 2'd1,
        EMIT   = 2'd2
    } state_t;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic even_par_ok(input logic [DATA_W-1:0] data,
                                         input logic              par);
        return ((^data) ^ par) == 1'b0;
    endfunction

endpackage

// File: rtl/ser2par8.sv
// ser2par8: accepts one serial bit per s_valid/s_ready handshake, assembles
// eight of them into a byte and presents it on d with a one-cycle en strobe
// that loads a downstream 8-bit register owned by the parent.
//
// Build option: define SER2PAR8_PARITY_EN to take a ninth, even-parity bit
// per frame; a parity mismatch produces a par_err strobe instead of en.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (highest priority)
//   clr        synchronous frame abort; discards the partial byte
//   s_valid    serial bit valid
//   s_data     serial bit
//   s_ready    block accepts a bit this cycle (low in EMIT and in reset)
//   d          registered assembled byte, updated only on a good frame
//   en         one-cycle load strobe for the downstream register
//   par_err    one-cycle parity-failure strobe (constant 0 without parity)
//   frame_cnt  count of bytes delivered via en, wraps 255 -> 0
//
// Parameter:
//   MSB_FIRST  0: first accepted bit lands in bit 0; 1: in bit 7
module ser2par8
    import ser2par8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              s_valid,
    input  logic              s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] d,
    output logic              en,
    output logic              par_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(DATA_W - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic [DATA_W-1:0]   shreg_ins;
    logic [CNT_W-1:0]    pos;
    logic [DATA_W-1:0]   d_q, d_nxt;
    logic                en_q, en_nxt;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_nxt;
    logic                accept;
`ifdef SER2PAR8_PARITY_EN
    logic                perr_q, perr_nxt;
`endif

    // Handshake: ready everywhere except the EMIT cycle and during reset.
    assign s_ready = ~reset & (state != EMIT);

    // A bit offered alongside clr is dropped along with the partial byte.
    assign accept = s_valid & s_ready & ~clr;

    // Byte position for the current bit, and the shift register with it merged.
    always_comb begin
        pos       = MSB_FIRST ? (LAST_POS - cnt) : cnt;
        shreg_ins = shreg;
        shreg_ins[pos] = s_data;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        d_nxt     = d_q;
        en_nxt    = 1'b0;
        fcnt_nxt  = fcnt_q;
`ifdef SER2PAR8_PARITY_EN
        perr_nxt  = 1'b0;
`endif

        unique case (state)
            SHIFT: begin
                if (accept) begin
                    shreg_nxt = shreg_ins;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == LAST_POS) begin
`ifdef SER2PAR8_PARITY_EN
                        state_nxt = PARITY;
`else
                        // Byte, strobe and count all land together so the
                        // EMIT cycle shows the new byte with en high.
                        state_nxt = EMIT;
                        d_nxt     = shreg_ins;
                        en_nxt    = 1'b1;
                        fcnt_nxt  = fcnt_q + FCNT_W'(1);
`endif
                    end
                end
            end

            PARITY: begin
`ifdef SER2PAR8_PARITY_EN
                if (accept) begin
                    state_nxt = EMIT;
                    if (even_par_ok(shreg, s_data)) begin
                        d_nxt    = shreg;
                        en_nxt   = 1'b1;
                        fcnt_nxt = fcnt_q + FCNT_W'(1);
                    end else begin
                        perr_nxt = 1'b1;
                    end
                end
`else
                state_nxt = SHIFT;
`endif
            end

            EMIT: begin
                state_nxt = SHIFT;
            end

            default: begin
                state_nxt = SHIFT;
            end
        endcase

        // Abort: the strobes already registered for an EMIT cycle still
        // complete; only the in-progress frame is thrown away.
        if (clr) begin
            state_nxt = SHIFT;
            cnt_nxt   = '0;
            shreg_nxt = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= SHIFT;
            cnt    <= '0;
            shreg  <= '0;
            d_q    <= '0;
            en_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            d_q    <= d_nxt;
            en_q   <= en_nxt;
            fcnt_q <= fcnt_nxt;
        end
    end

`ifdef SER2PAR8_PARITY_EN
    // Parity-failure strobe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_nxt;
        end
    end

    assign par_err = perr_q;
`else
    assign par_err = 1'b0;
`endif

    assign d         = d_q;
    assign en        = en_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_ser2par8.sv
// tb_ser2par8: scoreboard bench for ser2par8 (MSB_FIRST=0). Stimulus pushes
// the expected frame result; a negedge monitor pops and compares whenever
// the DUT strobes en or par_err. Honors SER2PAR8_PARITY_EN when defined.
module tb_ser2par8;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       s_valid;
    logic       s_data;
    logic       s_ready;
    logic [7:0] d;
    logic       en;
    logic       par_err;
    logic [7:0] frame_cnt;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] fc;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_fc = 8'h00;
    logic [7:0] last_d = 8'h00;
    logic       prev_en = 1'b0;

    logic b_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    ser2par8 #(.MSB_FIRST(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .d         (d),
        .en        (en),
        .par_err   (par_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one bit and hold it until the DUT accepts it.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", 8'(s_ready), 8'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    // LSB-first frame; bad_par flips the parity bit in parity builds.
    task automatic send_frame(input logic [7:0] v, input int gap, input logic bad_par);
        if (bad_par) begin
            sb.push_back('{d: last_d, fc: exp_fc, err: 1'b1});
        end else begin
            exp_fc = exp_fc + 8'd1;
            last_d = v;
            sb.push_back('{d: v, fc: exp_fc, err: 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i]);
            if (gap > 0) idle(gap);
        end
`ifdef SER2PAR8_PARITY_EN
        send_bit((^v) ^ bad_par);
`endif
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b0;
        clr     = 1'b0;
        repeat (n) @(negedge clk);
        reset  = 1'b0;
        exp_fc = 8'h00;
        last_d = 8'h00;
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && (en || par_err)) begin
            chk("en_single_cycle", 8'(prev_en), 8'd0);
            chk("ready_low_in_emit", 8'(s_ready), 8'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_emit: got en=%0b par_err=%0b d=%0h expected no strobe",
                         en, par_err, d);
            end else begin
                e = sb.pop_front();
                chk("emit_d", d, e.d);
                chk("emit_frame_cnt", frame_cnt, e.fc);
                chk("emit_en", 8'(en), 8'(!e.err));
                chk("emit_par_err", 8'(par_err), 8'(e.err));
            end
        end
        prev_en = en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d", d, 8'h00);
        chk("rst_en", 8'(en), 8'd0);
        chk("rst_par_err", 8'(par_err), 8'd0);
        chk("rst_frame_cnt", frame_cnt, 8'h00);
        chk("rst_ready", 8'(s_ready), 8'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 8'(s_ready), 8'd1);

        // Bits 1,0,1,1,0,0,1,0 back-to-back -> 8'h4D.
        exp_fc = 8'd1;
        last_d = 8'h4D;
        sb.push_back('{d: 8'h4D, fc: 8'd1, err: 1'b0});
        for (int i = 0; i < 8; i++) send_bit(b_seq[i]);
`ifdef SER2PAR8_PARITY_EN
        send_bit(1'b0);
`endif
        idle(3);
        chk("b2b_d_hold", d, 8'h4D);
        chk("b2b_frame_cnt", frame_cnt, 8'd1);

        // Same bits with a one-cycle gap between each.
        exp_fc = 8'd2;
        sb.push_back('{d: 8'h4D, fc: 8'd2, err: 1'b0});
        for (int i = 0; i < 8; i++) begin
            send_bit(b_seq[i]);
            idle(1);
        end
`ifdef SER2PAR8_PARITY_EN
        send_bit(1'b0);
`endif
        idle(3);
        chk("gap_d_hold", d, 8'h4D);
        chk("gap_frame_cnt", frame_cnt, 8'd2);

        // Five ones, abort with a bit offered in the clr cycle, then 8'hA5.
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        @(negedge clk);
        clr     = 1'b1;
        s_valid = 1'b1;
        s_data  = 1'b1;
        @(negedge clk);
        clr     = 1'b0;
        s_valid = 1'b0;
        chk("clr_d_kept", d, 8'h4D);
        chk("clr_frame_cnt_kept", frame_cnt, 8'd2);
        chk("clr_no_en", 8'(en), 8'd0);
        send_frame(8'hA5, 0, 1'b0);
        idle(3);
        chk("after_clr_d", d, 8'hA5);
        chk("after_clr_frame_cnt", frame_cnt, 8'd3);

        // 256 frames from reset: counter wraps back to zero.
        do_reset(2);
        for (int i = 0; i < 256; i++) send_frame(8'(i * 37 + 11), 0, 1'b0);
        idle(3);
        chk("wrap_frame_cnt", frame_cnt, 8'h00);
        chk("wrap_last_d", d, 8'(255 * 37 + 11));

        // Reset after the 4th bit of a frame: no strobe, reset values.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_d", d, 8'h00);
        chk("midrst_en", 8'(en), 8'd0);
        chk("midrst_par_err", 8'(par_err), 8'd0);
        chk("midrst_frame_cnt", frame_cnt, 8'h00);
        chk("midrst_ready", 8'(s_ready), 8'd0);
        reset  = 1'b0;
        exp_fc = 8'h00;
        last_d = 8'h00;
        send_frame(8'h3C, 0, 1'b0);
        idle(3);
        chk("post_midrst_d", d, 8'h3C);
        chk("post_midrst_frame_cnt", frame_cnt, 8'd1);

`ifdef SER2PAR8_PARITY_EN
        // 8'h03 with good parity, then with bad parity.
        send_frame(8'h03, 0, 1'b0);
        idle(3);
        chk("par_ok_d", d, 8'h03);
        chk("par_ok_frame_cnt", frame_cnt, 8'd2);
        send_frame(8'h03, 0, 1'b1);
        idle(3);
        chk("par_bad_d", d, 8'h03);
        chk("par_bad_frame_cnt", frame_cnt, 8'd2);
`endif

        idle(3);
        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ser2par8.md
SER2PAR8 -- requirements
Module: ser2par8

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter: MSB_FIRST, default 0, meaning 0 = first accepted bit lands in bit 0, 1 = first accepted bit lands in bit 7.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: clr  input  1  synchronous frame abort.
REQ-006 Port: s_valid  input  1  serial bit valid.
REQ-007 Port: s_data  input  1  serial bit.
REQ-008 Port: s_ready  output  1  block accepts a bit this cycle.
REQ-009 Port: d  output  8  assembled byte; drives the downstream 8-bit register data input.
REQ-010 Port: en  output  1  one-cycle load strobe; drives the downstream register enable.
REQ-011 Port: par_err  output  1  one-cycle parity-failure strobe.
REQ-012 Port: frame_cnt  output  8  count of bytes delivered via en.

Function
REQ-013 Bit acceptance SHALL occur only on a cycle where s_valid=1 and s_ready=1.
REQ-014 States SHALL be SHIFT, PARITY (present only with the macro), and EMIT.
REQ-015 SHIFT SHALL hold a 3-bit counter cnt; each accepted bit SHALL be written to byte position cnt (MSB_FIRST=0) or 7-cnt (MSB_FIRST=1), then cnt increments.
REQ-016 On the accept with cnt=7, the state SHALL go to PARITY if compiled in, else to EMIT; cnt SHALL wrap to 0.
REQ-017 s_ready SHALL be 1 in SHIFT and PARITY, 0 in EMIT, and 0 while reset=1.
REQ-018 EMIT SHALL last exactly one cycle and then return to SHIFT.
REQ-019 In the EMIT cycle, d SHALL present the new byte and en SHALL be 1; latency is one cycle from the last accepted bit to en.
REQ-020 d SHALL be registered and hold its value until the next successful EMIT; the partial byte SHALL never appear on d.
REQ-021 en and par_err SHALL be 0 in every cycle except EMIT.
REQ-022 frame_cnt SHALL increment on every cycle with en=1 and wrap 255 -> 0.
REQ-023 clr=1 SHALL force SHIFT with cnt=0 and discard the partial byte; a bit offered in the same cycle SHALL be discarded.
REQ-024 If clr=1 during EMIT, en/par_err SHALL still complete that cycle.
REQ-025 d and frame_cnt SHALL be unaffected by clr.
REQ-026 Gaps in s_valid SHALL NOT alter the partial byte or cnt.

Reset
REQ-027 reset SHALL take priority over clr and all inputs.
REQ-028 Reset values SHALL be: state=SHIFT, cnt=0, d=8'h00, en=0, par_err=0, frame_cnt=8'h00, shift register=0.
REQ-029 Reset asserted mid-frame or in EMIT SHALL abort the frame with no en pulse.

Configuration
REQ-030 Macro SER2PAR8_PARITY_EN SHALL control parity checking.
REQ-031 With SER2PAR8_PARITY_EN defined, a ninth accepted bit SHALL be taken in PARITY as an even-parity bit.
REQ-032 With the macro defined, on match EMIT SHALL assert en; on mismatch EMIT SHALL assert par_err=1 with en=0, d SHALL keep its old value, and frame_cnt SHALL not increment.
REQ-033 Without the macro, there SHALL be no PARITY state, par_err SHALL be constant 0, and frames SHALL be 8 bits.

Structure
REQ-034 Package ser2par8_pkg SHALL hold: state enum (SHIFT, PARITY, EMIT), DATA_W=8, CNT_W=3, FCNT_W=8.
REQ-035 No sub-module SHALL be used; the counter and shift register are inline.
REQ-036 The downstream register SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 The bench SHALL cover: after reset, bits 1,0,1,1,0,0,1,0 sent back-to-back with MSB_FIRST=0 -> next cycle en=1, d=8'h4D, frame_cnt=1.
REQ-038 The bench SHALL cover: same bits with s_valid low on alternate cycles -> identical d=8'h4D, en one cycle only, s_ready=0 in EMIT.
REQ-039 The bench SHALL cover: 5 bits, then clr, then 8 bits of 8'hA5 -> en once, d=8'hA5, no trace of the first 5 bits.
REQ-040 The bench SHALL cover: 256 frames -> frame_cnt wraps to 8'h00; reset asserted after the 4th bit of a frame -> no en, all outputs at reset values.
REQ-041 The bench SHALL cover, with SER2PAR8_PARITY_EN: byte 8'h03 with parity bit 0 -> en=1, d=8'h03.
REQ-042 The bench SHALL cover, with SER2PAR8_PARITY_EN: byte 8'h03 with parity bit 1 -> par_err=1, en=0, d unchanged, frame_cnt unchanged.
